// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the req/ack handshake with
// instruction memory and holds one fetched word for the decoder.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | out of reset, no request; next cycle starts fetching
// S_FETCH | request outstanding at pc, waiting for ack
// S_DRAIN | redirected mid-fetch; finish old transaction, then go to target
// S_HOLD  | output register holds a valid instruction for decode
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [31:0]       ins,
    output logic [5:0]        ins_op,
    output logic [5:0]        func_code,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus4,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] redir_al;

    // Redirect targets are forced word-aligned; low bits are dropped by masking.
    assign redir_al  = redirect_pc & ~ADDR_W'(3);

    // While draining, pc still holds the old address, so the address bus
    // stays stable until the outstanding transaction is acked.
    assign imem_addr = pc;
    assign pc_plus4  = pc_out + ADDR_W'(4);
    assign ins_op    = ins[31:26];
    assign func_code = ins[5:0];

    // Fetch FSM with registered request/valid/instruction outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            target    <= '0;
            imem_req  <= 1'b0;
            ins_valid <= 1'b0;
            ins       <= '0;
            pc_out    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (redirect) pc <= redir_al;
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        if (redirect) begin
                            // Stale word dropped; request re-issues at new pc.
                            pc <= redir_al;
                        end else begin
                            ins       <= imem_rdata;
                            pc_out    <= pc;
                            ins_valid <= 1'b1;
                            pc        <= pc + ADDR_W'(4);
                            imem_req  <= 1'b0;
                            state     <= S_HOLD;
                        end
                    end else if (redirect) begin
                        target <= redir_al;
                        state  <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (imem_ack) begin
                        pc    <= redirect ? redir_al : target;
                        state <= S_FETCH;
                    end else if (redirect) begin
                        target <= redir_al;
                    end
                end
                S_HOLD: begin
                    if (redirect) begin
                        // Squash takes priority over consumption.
                        ins_valid <= 1'b0;
                        pc        <= redir_al;
                        imem_req  <= 1'b1;
                        state     <= S_FETCH;
                    end else if (ins_ready) begin
                        ins_valid <= 1'b0;
                        imem_req  <= 1'b1;
                        state     <= S_FETCH;
                    end
                end
                default: begin
                    imem_req  <= 1'b0;
                    ins_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: one instance at RESET_PC=0, one at the
// top word of the address space to exercise PC wrap-around.
module tb_fetch_unit;

    logic        clk;
    logic        rst_a, rst_b;
    logic        ack, ready, redir;
    logic [31:0] rdata, redir_pc;
    logic        sel;

    logic        a_req, a_valid, b_req, b_valid;
    logic [31:0] a_addr, a_ins, a_pc, a_pc4, b_addr, b_ins, b_pc, b_pc4;
    logic [5:0]  a_op, a_fn, b_op, b_fn;

    logic        o_req, o_valid;
    logic [31:0] o_addr, o_ins, o_pc, o_pc4;
    logic [5:0]  o_op, o_fn;

    int n_cmp = 0;
    int n_err = 0;

    fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut_a (
        .clk(clk), .rst_n(rst_a),
        .imem_req(a_req), .imem_addr(a_addr), .imem_ack(ack), .imem_rdata(rdata),
        .ins_valid(a_valid), .ins_ready(ready), .ins(a_ins),
        .ins_op(a_op), .func_code(a_fn), .pc_out(a_pc), .pc_plus4(a_pc4),
        .redirect(redir), .redirect_pc(redir_pc)
    );

    fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_b (
        .clk(clk), .rst_n(rst_b),
        .imem_req(b_req), .imem_addr(b_addr), .imem_ack(ack), .imem_rdata(rdata),
        .ins_valid(b_valid), .ins_ready(ready), .ins(b_ins),
        .ins_op(b_op), .func_code(b_fn), .pc_out(b_pc), .pc_plus4(b_pc4),
        .redirect(redir), .redirect_pc(redir_pc)
    );

    always_comb begin
        o_req   = sel ? b_req   : a_req;
        o_valid = sel ? b_valid : a_valid;
        o_addr  = sel ? b_addr  : a_addr;
        o_ins   = sel ? b_ins   : a_ins;
        o_pc    = sel ? b_pc    : a_pc;
        o_pc4   = sel ? b_pc4   : a_pc4;
        o_op    = sel ? b_op    : a_op;
        o_fn    = sel ? b_fn    : a_fn;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    // Entered at a negedge with the DUT in S_FETCH; leaves it in S_HOLD.
    task automatic do_fetch(input logic [31:0] addr, input int waits, input logic [31:0] data);
        for (int i = 0; i < waits; i++) begin
            chk("wait_req", {31'd0, o_req}, 32'd1);
            chk("wait_addr", o_addr, addr);
            chk("wait_valid", {31'd0, o_valid}, 32'd0);
            ack = 1'b0;
            step();
        end
        chk("req", {31'd0, o_req}, 32'd1);
        chk("addr", o_addr, addr);
        ack   = 1'b1;
        rdata = data;
        step();
        ack   = 1'b0;
        chk("valid", {31'd0, o_valid}, 32'd1);
        chk("ins", o_ins, data);
        chk("pc_out", o_pc, addr);
        chk("pc_plus4", o_pc4, addr + 32'd4);
        chk("hold_req", {31'd0, o_req}, 32'd0);
    endtask

    // Consume the held instruction; leaves the DUT in S_FETCH.
    task automatic consume;
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("consumed_valid", {31'd0, o_valid}, 32'd0);
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; sel = 1'b0;
        ack = 1'b0; ready = 1'b0; redir = 1'b0;
        rdata = '0; redir_pc = '0;
        step(); step();
        chk("rst_req", {31'd0, o_req}, 32'd0);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_ins", o_ins, 32'd0);
        chk("rst_pc_out", o_pc, 32'd0);

        rst_a = 1'b1;
        step();
        do_fetch(32'h0, 0, 32'hAAAA_0001);
        consume();
        do_fetch(32'h4, 3, 32'hAAAA_0002);
        consume();
        do_fetch(32'h8, 0, 32'h2008_0005);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", {31'd0, o_valid}, 32'd1);
            chk("stall_op", {26'd0, o_op}, 32'h08);
            chk("stall_fn", {26'd0, o_fn}, 32'h05);
            chk("stall_pc", o_pc, 32'h8);
            chk("stall_req", {31'd0, o_req}, 32'd0);
        end
        consume();

        // Redirect while the fetch at 0xC is waiting; ack arrives 2 cycles later.
        chk("pre_redir_addr", o_addr, 32'hC);
        redir = 1'b1; redir_pc = 32'h40;
        step();
        redir = 1'b0;
        chk("drain_req", {31'd0, o_req}, 32'd1);
        chk("drain_addr", o_addr, 32'hC);
        step();
        chk("drain_addr2", o_addr, 32'hC);
        ack = 1'b1; rdata = 32'hDEAD_BEEF;
        step();
        ack = 1'b0;
        chk("post_drain_valid", {31'd0, o_valid}, 32'd0);
        do_fetch(32'h40, 0, 32'hAAAA_0003);

        // Redirect in S_HOLD together with ins_ready; target low bits dropped.
        redir = 1'b1; redir_pc = 32'h103; ready = 1'b1;
        step();
        redir = 1'b0; ready = 1'b0;
        chk("squash_valid", {31'd0, o_valid}, 32'd0);
        chk("squash_req", {31'd0, o_req}, 32'd1);
        chk("squash_addr", o_addr, 32'h100);

        // Redirect on the ack cycle: data dropped, request moves to target.
        ack = 1'b1; rdata = 32'hDEAD_0001; redir = 1'b1; redir_pc = 32'h200;
        step();
        ack = 1'b0; redir = 1'b0;
        chk("ackredir_valid", {31'd0, o_valid}, 32'd0);
        chk("ackredir_req", {31'd0, o_req}, 32'd1);
        chk("ackredir_addr", o_addr, 32'h200);
        do_fetch(32'h200, 1, 32'hAAAA_0004);
        consume();

        // Two redirects while draining: the last one wins.
        redir = 1'b1; redir_pc = 32'h300;
        step();
        redir_pc = 32'h400;
        step();
        redir = 1'b0;
        chk("lastwin_old_addr", o_addr, 32'h204);
        ack = 1'b1; rdata = 32'hDEAD_0002;
        step();
        ack = 1'b0;
        chk("lastwin_addr", o_addr, 32'h400);
        chk("lastwin_valid", {31'd0, o_valid}, 32'd0);

        // Switch to the wrap-around instance.
        rst_a = 1'b0; sel = 1'b1; rst_b = 1'b1;
        step();
        do_fetch(32'hFFFF_FFFC, 0, 32'hBBBB_0001);
        chk("wrap_pc_plus4", o_pc4, 32'h0);
        consume();
        do_fetch(32'h0, 0, 32'hBBBB_0002);
        consume();
        chk("midwait_addr", o_addr, 32'h4);
        step();

        // Reset pulse mid-wait: request must drop before the next edge.
        #2 rst_b = 1'b0;
        #1 chk("async_req", {31'd0, o_req}, 32'd0);
        chk("async_valid", {31'd0, o_valid}, 32'd0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        step();
        rst_b = 1'b1;
        ack = 1'b1;   // stray ack while idle must be ignored
        step();
        ack = 1'b0;
        chk("restart_valid", {31'd0, o_valid}, 32'd0);
        chk("restart_req", {31'd0, o_req}, 32'd1);
        chk("restart_addr", o_addr, 32'hFFFF_FFFC);
        do_fetch(32'hFFFF_FFFC, 0, 32'hBBBB_0003);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
